ss_mux_driver: RTL and testbench

SS_MUX_DRIVER -- requirements
Module: ss_mux_driver

---
 rtl/ss_pkg.sv | 27 ++
 rtl/ss_digit_decoder.sv | 21 ++
 rtl/ss_mux_driver.sv | 158 +++++++++++++++
 tb/tb_ss_mux_driver.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ss_pkg.sv
// Shared constants for the seven-segment multiplexed display driver:
// segment bit positions, the hex glyph table and the blank glyph.
package ss_pkg;

  // Bit positions inside the 8-bit segment word (bit7 is the decimal point)
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Active-high a..g glyphs, entry k is the glyph for code k (F listed first)
  localparam logic [15:0][6:0] HEX_PATTERNS = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Active-high glyph with every segment dark
  localparam logic [6:0] BLANK_PATTERN = 7'h00;

  // Active-low output word with every segment and the DP dark
  localparam logic [7:0] SEG_ALL_OFF = 8'hFF;

endpackage

// File: rtl/ss_digit_decoder.sv
// Converts one 4-bit digit code into active-high a..g segments.
// BCD mode shows codes 10..15 as blank; hex mode shows 0..F.
module ss_digit_decoder
  import ss_pkg::*;
(
  input  logic [3:0] code,
  input  logic       hex_en,
  output logic [6:0] seg
);

  // Table lookup, with non-decimal codes suppressed in BCD mode
  always_comb begin
    seg = BLANK_PATTERN;
    if (hex_en || (code < 4'd10)) begin
      seg = HEX_PATTERNS[code];
    end else begin
      seg = BLANK_PATTERN;
    end
  end

endmodule

// File: rtl/ss_mux_driver.sv
// Time-multiplexed seven-segment driver: free-running prescaler selects the
// digit slot, frame-synchronous shadow/active data registers, leading-zero
// blanking and PWM brightness. All outputs are registered (one-clock latency).
module ss_mux_driver
  import ss_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int DIV_BITS    = 17,
  parameter int BRIGHT_BITS = 4
) (
  input  logic                    Clk,
  input  logic                    nReset,
  input  logic [4*NUM_DIGITS-1:0] Digits,
  input  logic [NUM_DIGITS-1:0]   DP,
  input  logic                    Load,
  input  logic                    Hex_En,
  input  logic                    Blank_Zeros,
  input  logic [BRIGHT_BITS-1:0]  Brightness,
  output logic [NUM_DIGITS-1:0]   SegmentDrivers,
  output logic [7:0]              SevenSegment,
  output logic                    Frame_Done
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_BITS-1:0]     prescaler_r;
  logic [IDX_W-1:0]        index_r;
  logic [4*NUM_DIGITS-1:0] shadow_digits_r;
  logic [NUM_DIGITS-1:0]   shadow_dp_r;
  logic [4*NUM_DIGITS-1:0] active_digits_r;
  logic [NUM_DIGITS-1:0]   active_dp_r;
  logic                    pending_r;
  logic [NUM_DIGITS-1:0]   drivers_r;
  logic [7:0]              segments_r;
  logic                    frame_done_r;

  logic                    tick_s;
  logic                    wrap_tick_s;
  logic [3:0]              code_s;
  logic                    dp_s;
  logic                    nonzero_above_s;
  logic                    blank_s;
  logic [6:0]              glyph_s;
  logic [6:0]              visible_s;
  logic                    enable_s;
  logic [NUM_DIGITS-1:0]   drivers_s;

  assign tick_s      = &prescaler_r;
  assign wrap_tick_s = tick_s && (index_r == LAST_IDX);

  // Prescaler and digit index: index advances once per full prescaler cycle
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      prescaler_r  <= '0;
      index_r      <= '0;
      frame_done_r <= 1'b0;
    end else begin
      prescaler_r  <= prescaler_r + DIV_BITS'(1);
      frame_done_r <= wrap_tick_s;
      if (wrap_tick_s) begin
        index_r <= '0;
      end else if (tick_s) begin
        index_r <= index_r + IDX_W'(1);
      end else begin
        index_r <= index_r;
      end
    end
  end

  // Shadow capture on Load; active copy only at a frame wrap so frames never mix
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      shadow_digits_r <= '0;
      shadow_dp_r     <= '0;
      active_digits_r <= '0;
      active_dp_r     <= '0;
      pending_r       <= 1'b0;
    end else begin
      if (Load) begin
        shadow_digits_r <= Digits;
        shadow_dp_r     <= DP;
      end else begin
        shadow_digits_r <= shadow_digits_r;
        shadow_dp_r     <= shadow_dp_r;
      end
      if (wrap_tick_s && Load) begin
        active_digits_r <= Digits;
        active_dp_r     <= DP;
        pending_r       <= 1'b0;
      end else if (wrap_tick_s && pending_r) begin
        active_digits_r <= shadow_digits_r;
        active_dp_r     <= shadow_dp_r;
        pending_r       <= 1'b0;
      end else if (Load) begin
        pending_r       <= 1'b1;
      end else begin
        pending_r       <= pending_r;
      end
    end
  end

  // Select the current digit and detect whether it is a leading zero
  always_comb begin
    code_s          = 4'h0;
    dp_s            = 1'b0;
    nonzero_above_s = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (IDX_W'(k) == index_r) begin
        code_s = active_digits_r[4*k +: 4];
        dp_s   = active_dp_r[k];
      end else begin
        code_s = code_s;
        dp_s   = dp_s;
      end
      if ((IDX_W'(k) >= index_r) && (active_digits_r[4*k +: 4] != 4'h0)) begin
        nonzero_above_s = 1'b1;
      end else begin
        nonzero_above_s = nonzero_above_s;
      end
    end
    blank_s = Blank_Zeros && (index_r != '0) && !nonzero_above_s;
  end

  ss_digit_decoder u_decoder (
    .code   (code_s),
    .hex_en (Hex_En),
    .seg    (glyph_s)
  );

  // Apply blanking and the PWM compare to form the next output values
  always_comb begin
    visible_s = blank_s ? BLANK_PATTERN : glyph_s;
    enable_s  = (prescaler_r[DIV_BITS-1 -: BRIGHT_BITS] <= Brightness);
    drivers_s = '1;
    if (enable_s) begin
      drivers_s[index_r] = 1'b0;
    end else begin
      drivers_s = '1;
    end
  end

  // Output registers; asynchronous reset darkens the display immediately
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      drivers_r  <= '1;
      segments_r <= SEG_ALL_OFF;
    end else begin
      drivers_r  <= drivers_s;
      segments_r <= ~{dp_s, visible_s};
    end
  end

  assign SegmentDrivers = drivers_r;
  assign SevenSegment   = segments_r;
  assign Frame_Done     = frame_done_r;

endmodule

// File: tb/tb_ss_mux_driver.sv
// Scoreboard bench for ss_mux_driver with small prescaler: a behavioural model
// predicts each registered output word, pushes it to a queue, and the value is
// popped and compared one clock later.
module tb_ss_mux_driver;

  localparam int N  = 4;
  localparam int DB = 4;
  localparam int BB = 2;

  logic          Clk = 1'b0;
  logic          nReset = 1'b0;
  logic [15:0]   Digits = 16'h0;
  logic [3:0]    DP = 4'h0;
  logic          Load = 1'b0;
  logic          Hex_En = 1'b0;
  logic          Blank_Zeros = 1'b0;
  logic [1:0]    Brightness = 2'd3;
  logic [3:0]    SegmentDrivers;
  logic [7:0]    SevenSegment;
  logic          Frame_Done;

  ss_mux_driver #(.NUM_DIGITS(N), .DIV_BITS(DB), .BRIGHT_BITS(BB)) dut (
    .Clk            (Clk),
    .nReset         (nReset),
    .Digits         (Digits),
    .DP             (DP),
    .Load           (Load),
    .Hex_En         (Hex_En),
    .Blank_Zeros    (Blank_Zeros),
    .Brightness     (Brightness),
    .SegmentDrivers (SegmentDrivers),
    .SevenSegment   (SevenSegment),
    .Frame_Done     (Frame_Done)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [3:0] drv;
    logic [7:0] seg;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   passed = 0;
  int   on_cnt = 0;
  int   fd_cnt = 0;

  // Reference model state
  int          m_pre = 0;
  int          m_idx = 0;
  logic [15:0] m_act = 16'h0;
  logic [3:0]  m_act_dp = 4'h0;
  logic [15:0] m_sh = 16'h0;
  logic [3:0]  m_sh_dp = 4'h0;
  logic        m_pend = 1'b0;

  // Active-low glyphs including DP bit (off)
  function automatic logic [7:0] glyph(input logic [3:0] c);
    case (c)
      4'h0: glyph = 8'hC0; 4'h1: glyph = 8'hF9; 4'h2: glyph = 8'hA4; 4'h3: glyph = 8'hB0;
      4'h4: glyph = 8'h99; 4'h5: glyph = 8'h92; 4'h6: glyph = 8'h82; 4'h7: glyph = 8'hF8;
      4'h8: glyph = 8'h80; 4'h9: glyph = 8'h90; 4'hA: glyph = 8'h88; 4'hB: glyph = 8'h83;
      4'hC: glyph = 8'hC6; 4'hD: glyph = 8'hA1; 4'hE: glyph = 8'h86; default: glyph = 8'h8E;
    endcase
  endfunction

  task automatic model_reset();
    m_pre = 0; m_idx = 0; m_act = 16'h0; m_act_dp = 4'h0;
    m_sh = 16'h0; m_sh_dp = 4'h0; m_pend = 1'b0;
    exp_q.delete();
  endtask

  // One clock: predict, push, clock, pop and compare, advance model
  task automatic step();
    exp_t e;
    exp_t got;
    logic [3:0] code;
    logic [7:0] g;
    logic en;
    logic blank;
    logic wrap;
    code  = m_act[m_idx*4 +: 4];
    en    = (m_pre / 4) <= int'(Brightness);
    blank = Blank_Zeros && (m_idx != 0) && ((m_act >> (m_idx*4)) == 16'h0);
    g     = glyph(code);
    if (!Hex_En && code > 4'd9) g = 8'hFF;
    if (blank) g = 8'hFF;
    g[7]  = ~m_act_dp[m_idx];
    e.seg = g;
    e.drv = 4'hF;
    if (en) e.drv[m_idx] = 1'b0;
    wrap  = (m_pre == 15) && (m_idx == N - 1);
    e.fd  = wrap;
    exp_q.push_back(e);
    if (wrap && Load) begin
      m_act = Digits; m_act_dp = DP; m_sh = Digits; m_sh_dp = DP; m_pend = 1'b0;
    end else if (wrap && m_pend) begin
      m_act = m_sh; m_act_dp = m_sh_dp; m_pend = 1'b0;
      if (Load) begin m_sh = Digits; m_sh_dp = DP; end
    end else if (Load) begin
      m_sh = Digits; m_sh_dp = DP; m_pend = 1'b1;
    end
    @(posedge Clk);
    #1;
    got = exp_q.pop_front();
    total++;
    if (SegmentDrivers !== got.drv)
      $display("FAIL drivers idx=%0d pre=%0d: got %h expected %h", m_idx, m_pre, SegmentDrivers, got.drv);
    else passed++;
    if (got.drv != 4'hF) begin
      total++;
      if (SevenSegment !== got.seg)
        $display("FAIL segments idx=%0d pre=%0d: got %h expected %h", m_idx, m_pre, SevenSegment, got.seg);
      else passed++;
    end
    total++;
    if (Frame_Done !== got.fd)
      $display("FAIL frame_done idx=%0d pre=%0d: got %b expected %b", m_idx, m_pre, Frame_Done, got.fd);
    else passed++;
    if (SegmentDrivers != 4'hF) on_cnt++;
    if (Frame_Done === 1'b1) fd_cnt++;
    if (m_pre == 15) m_idx = (m_idx + 1) % N;
    m_pre = (m_pre + 1) % 16;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic step_until(input int pre, input int idx);
    for (int i = 0; i < 64 && !(m_pre == pre && m_idx == idx); i++) step();
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    total++;
    if (SegmentDrivers !== 4'hF || SevenSegment !== 8'hFF || Frame_Done !== 1'b0)
      $display("FAIL reset_state: got %h/%h/%b expected f/ff/0", SegmentDrivers, SevenSegment, Frame_Done);
    else passed++;
    nReset = 1'b1;
    model_reset();
    run(1);
    total++;
    if (SegmentDrivers !== 4'hE)
      $display("FAIL reset_release_digit0: got %h expected e", SegmentDrivers);
    else passed++;
  endtask

  task automatic test_basic();
    Brightness = 2'd3; Digits = 16'h1230; DP = 4'h0; Load = 1'b1;
    step();
    Load = 1'b0;
    step_until(0, 0);
    fd_cnt = 0;
    run(128);
    total++;
    if (fd_cnt != 2) $display("FAIL frame_done_rate: got %0d expected 2", fd_cnt);
    else passed++;
  endtask

  task automatic test_blank();
    Digits = 16'h0050; DP = 4'b0100; Blank_Zeros = 1'b1; Load = 1'b1;
    step();
    Load = 1'b0;
    run(128);
    Blank_Zeros = 1'b0;
    run(64);
  endtask

  task automatic test_hex();
    Digits = 16'h000A; DP = 4'h0; Hex_En = 1'b1; Load = 1'b1;
    step();
    Load = 1'b0;
    run(128);
    Hex_En = 1'b0;
    run(64);
  endtask

  task automatic test_brightness();
    Digits = 16'h4321; Load = 1'b1;
    step();
    Load = 1'b0;
    Brightness = 2'd0;
    step_until(0, 0);
    on_cnt = 0;
    run(64);
    total++;
    if (on_cnt != 16) $display("FAIL bright0_on: got %0d expected 16", on_cnt);
    else passed++;
    Brightness = 2'd2;
    on_cnt = 0;
    run(64);
    total++;
    if (on_cnt != 48) $display("FAIL bright2_on: got %0d expected 48", on_cnt);
    else passed++;
    Brightness = 2'd3;
  endtask

  task automatic test_load_timing();
    step_until(5, 1);
    Digits = 16'h9876; DP = 4'b0001; Load = 1'b1;
    step();
    Load = 1'b0;
    run(100);
    step_until(15, N - 1);
    Digits = 16'hBEEF; DP = 4'b1000; Hex_En = 1'b1; Load = 1'b1;
    step();
    Load = 1'b0;
    run(64);
    Hex_En = 1'b0;
  endtask

  task automatic test_async_reset();
    step_until(7, 2);
    Digits = 16'h5555; Load = 1'b1;
    step();
    Load = 1'b0;
    run(3);
    #2 nReset = 1'b0;
    #1;
    total++;
    if (SegmentDrivers !== 4'hF || SevenSegment !== 8'hFF || Frame_Done !== 1'b0)
      $display("FAIL async_reset: got %h/%h/%b expected f/ff/0", SegmentDrivers, SevenSegment, Frame_Done);
    else passed++;
    repeat (3) @(posedge Clk);
    #1 nReset = 1'b1;
    model_reset();
    run(1);
    total++;
    if (SegmentDrivers !== 4'hE || SevenSegment !== 8'hC0)
      $display("FAIL post_reset_digit0: got %h/%h expected e/c0", SegmentDrivers, SevenSegment);
    else passed++;
    run(100);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_blank();
    test_hex();
    test_brightness();
    test_load_timing();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
